// File: rtl/read_checker.sv
// read_checker: read-domain FIFO agent that pops every word and checks odd parity and sequence
// Ports: rclk/rrst clock and async active-high reset; rempty/rdata FIFO flag and head word;
//        rinc pop strobe; rword/rvalid last word and one-cycle update pulse; rcount words popped;
//        perr/serr sticky parity/sequence errors; err_cnt saturating count of bad words.
module read_checker #(
    parameter int              DW         = 16,
    parameter int              CW         = 16,
    parameter logic [DW-1:0]   FIRST_WORD = 16'h0001,
    parameter int              GAP        = 0
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          rempty,
    input  logic [DW-1:0] rdata,
    output logic          rinc,
    output logic [DW-1:0] rword,
    output logic          rvalid,
    output logic [CW-1:0] rcount,
    output logic          perr,
    output logic          serr,
    output logic [CW-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, POP, CHECK, WAIT} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] rword_q, rword_d, prev_q, prev_d, diff;
    logic [CW-1:0] rcount_q, rcount_d, err_cnt_q, err_cnt_d;
    logic [7:0]    gap_q, gap_d;
    logic          rvalid_q, rvalid_d, perr_q, perr_d, serr_q, serr_d, first_q, first_d;
    logic          par_err, seq_err;
    always_comb begin
        diff      = rword_q - prev_q;
        par_err   = ~^rword_q;
        // consecutive odd-parity values are 1..3 apart, modulo wrap
        seq_err   = first_q ? (rword_q != FIRST_WORD) : (diff == '0 || diff > DW'(3));
        state_d   = state_q;
        rword_d   = rword_q;
        prev_d    = prev_q;
        rcount_d  = rcount_q;
        err_cnt_d = err_cnt_q;
        gap_d     = gap_q;
        perr_d    = perr_q;
        serr_d    = serr_q;
        first_d   = first_q;
        rvalid_d  = state_q == CHECK;
        case (state_q)
            IDLE: state_d = rempty ? IDLE : POP;
            POP: begin
                state_d = CHECK;
                rword_d = rdata;
            end
            CHECK: begin
                state_d   = (GAP > 0) ? WAIT : IDLE;
                gap_d     = '0;
                rcount_d  = rcount_q + CW'(1);
                prev_d    = rword_q;
                first_d   = 1'b0;
                perr_d    = perr_q | par_err;
                serr_d    = serr_q | seq_err;
                err_cnt_d = ((par_err || seq_err) && !(&err_cnt_q)) ? err_cnt_q + CW'(1) : err_cnt_q;
            end
            WAIT: begin
                gap_d   = gap_q + 8'd1;
                state_d = (gap_q == 8'(GAP - 1)) ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q   <= IDLE;
            rword_q   <= '0;
            prev_q    <= '0;
            rcount_q  <= '0;
            err_cnt_q <= '0;
            gap_q     <= '0;
            rvalid_q  <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            rword_q   <= rword_d;
            prev_q    <= prev_d;
            rcount_q  <= rcount_d;
            err_cnt_q <= err_cnt_d;
            gap_q     <= gap_d;
            rvalid_q  <= rvalid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            first_q   <= first_d;
        end
    end
    assign rinc    = state_q == POP;
    assign rword   = rword_q;
    assign rvalid  = rvalid_q;
    assign rcount  = rcount_q;
    assign perr    = perr_q;
    assign serr    = serr_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_read_checker.sv
// tb_read_checker: directed tests of read_checker against small FIFO models
module tb_read_checker;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rempty, rinc, rvalid, perr, serr;
    logic        rempty_g, rinc_g, rvalid_g, perr_g, serr_g;
    logic [15:0] rdata, rword, rcount, err_cnt;
    logic [15:0] rdata_g, rword_g, rcount_g, err_cnt_g;
    logic [15:0] mem [64];
    logic [15:0] mem_g [64];
    logic [5:0]  wp = '0, rp, wp_g = '0, rp_g;
    int          checks = 0, errors = 0;
    int          pt [16];
    int          np, nv;
    logic [15:0] vw [16];
    logic [15:0] ve [16];

    always #5 clk = ~clk;

    read_checker #(.GAP(0)) dut (
        .rclk(clk), .rrst(rst), .rempty(rempty), .rdata(rdata), .rinc(rinc), .rword(rword),
        .rvalid(rvalid), .rcount(rcount), .perr(perr), .serr(serr), .err_cnt(err_cnt)
    );
    read_checker #(.GAP(4)) dut_g (
        .rclk(clk), .rrst(rst), .rempty(rempty_g), .rdata(rdata_g), .rinc(rinc_g), .rword(rword_g),
        .rvalid(rvalid_g), .rcount(rcount_g), .perr(perr_g), .serr(serr_g), .err_cnt(err_cnt_g)
    );

    assign rempty   = rp == wp;
    assign rdata    = mem[rp];
    assign rempty_g = rp_g == wp_g;
    assign rdata_g  = mem_g[rp_g];

    always @(posedge clk or posedge rst)
        if (rst) begin
            rp   <= '0;
            rp_g <= '0;
        end else begin
            if (rinc)   rp   <= rp + 6'd1;
            if (rinc_g) rp_g <= rp_g + 6'd1;
        end

    task automatic push(input bit g, input logic [15:0] v);
        if (g) begin
            mem_g[wp_g] = v;
            wp_g = wp_g + 6'd1;
        end else begin
            mem[wp] = v;
            wp = wp + 6'd1;
        end
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst = 1'b1;
        wp = '0;
        wp_g = '0;
        @(negedge clk);
    endtask

    task automatic run(input bit g, input int n);
        np = 0;
        nv = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if ((g ? rinc_g : rinc) && np < 16) begin
                pt[np] = c;
                np++;
            end
            if (!g && rvalid && nv < 16) begin
                vw[nv] = rword;
                ve[nv] = err_cnt;
                nv++;
            end
        end
    endtask

    task automatic test_reset();
        begin_reset();
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", rinc); end
        checks++; if (rword !== 16'h0) begin errors++; $display("FAIL reset_rword: got %h want 0000", rword); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        checks++; if (rcount !== 16'h0) begin errors++; $display("FAIL reset_rcount: got %h want 0000", rcount); end
        checks++; if ({perr, serr} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {perr, serr}); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
        checks++; if (rinc_g !== 1'b0) begin errors++; $display("FAIL reset_rinc_g: got %b want 0", rinc_g); end
        rst = 1'b0;
    endtask

    task automatic test_drain();
        logic [15:0] e [4];
        e = '{16'h0001, 16'h0002, 16'h0004, 16'h0007};
        begin_reset();
        for (int i = 0; i < 4; i++) push(0, e[i]);
        rst = 1'b0;
        run(0, 20);
        checks++; if (np !== 4) begin errors++; $display("FAIL drain_pops: got %0d want 4", np); end
        checks++; if (pt[0] !== 0) begin errors++; $display("FAIL drain_latency: got %0d want 0", pt[0]); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (pt[i] - pt[i-1] !== 3) begin errors++; $display("FAIL drain_spacing%0d: got %0d want 3", i, pt[i] - pt[i-1]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vw[i] !== e[i]) begin errors++; $display("FAIL drain_word%0d: got %h want %h", i, vw[i], e[i]); end
        end
        checks++; if (rcount !== 16'd4) begin errors++; $display("FAIL drain_rcount: got %0d want 4", rcount); end
        checks++; if ({perr, serr} !== 2'b00) begin errors++; $display("FAIL drain_flags: got %b want 00", {perr, serr}); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL drain_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_parity();
        begin_reset();
        push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h0003); push(0, 16'h0004);
        rst = 1'b0;
        run(0, 20);
        checks++; if (ve[2] !== 16'd1) begin errors++; $display("FAIL parity_err_cnt_at: got %0d want 1", ve[2]); end
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL parity_perr: got %b want 1", perr); end
        checks++; if (serr !== 1'b0) begin errors++; $display("FAIL parity_serr: got %b want 0", serr); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL parity_err_cnt: got %0d want 1", err_cnt); end
        checks++; if (rcount !== 16'd4) begin errors++; $display("FAIL parity_rcount: got %0d want 4", rcount); end
    endtask

    task automatic test_sequence();
        begin_reset();
        push(0, 16'h0001); push(0, 16'h0008); push(0, 16'h000B);
        rst = 1'b0;
        run(0, 16);
        checks++; if (ve[1] !== 16'd1) begin errors++; $display("FAIL seq_jump_err_cnt: got %0d want 1", ve[1]); end
        checks++; if (serr !== 1'b1) begin errors++; $display("FAIL seq_serr: got %b want 1", serr); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL seq_perr: got %b want 0", perr); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL seq_err_cnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_wrap();
        begin_reset();
        push(0, 16'h0001); push(0, 16'hFFFE); push(0, 16'h0001); push(0, 16'h0001); push(0, 16'h0000);
        rst = 1'b0;
        run(0, 20);
        checks++; if (nv !== 5) begin errors++; $display("FAIL wrap_count: got %0d want 5", nv); end
        checks++; if (ve[1] !== 16'd1) begin errors++; $display("FAIL wrap_jump: got %0d want 1", ve[1]); end
        checks++; if (ve[2] !== 16'd1) begin errors++; $display("FAIL wrap_legal: got %0d want 1", ve[2]); end
        checks++; if (ve[3] !== 16'd2) begin errors++; $display("FAIL wrap_duplicate: got %0d want 2", ve[3]); end
        checks++; if (ve[4] !== 16'd3) begin errors++; $display("FAIL wrap_both_once: got %0d want 3", ve[4]); end
        checks++; if ({perr, serr} !== 2'b11) begin errors++; $display("FAIL wrap_flags: got %b want 11", {perr, serr}); end
    endtask

    task automatic test_idle();
        begin_reset();
        rst = 1'b0;
        run(0, 20);
        checks++; if (np !== 0) begin errors++; $display("FAIL idle_rinc: got %0d pulses want 0", np); end
        checks++; if (nv !== 0) begin errors++; $display("FAIL idle_rvalid: got %0d pulses want 0", nv); end
        checks++; if (dut.state_q !== 2'b00) begin errors++; $display("FAIL idle_state: got %0d want 0", dut.state_q); end
        checks++; if (rcount !== 16'd0) begin errors++; $display("FAIL idle_rcount: got %0d want 0", rcount); end
    endtask

    task automatic test_gap();
        begin_reset();
        push(1, 16'h0001); push(1, 16'h0002); push(1, 16'h0004);
        rst = 1'b0;
        run(1, 30);
        checks++; if (np !== 3) begin errors++; $display("FAIL gap_pops: got %0d want 3", np); end
        checks++; if (pt[1] - pt[0] !== 7) begin errors++; $display("FAIL gap_spacing1: got %0d want 7", pt[1] - pt[0]); end
        checks++; if (pt[2] - pt[1] !== 7) begin errors++; $display("FAIL gap_spacing2: got %0d want 7", pt[2] - pt[1]); end
        checks++; if (rcount_g !== 16'd3) begin errors++; $display("FAIL gap_rcount: got %0d want 3", rcount_g); end
        checks++; if (err_cnt_g !== 16'd0) begin errors++; $display("FAIL gap_err_cnt: got %0d want 0", err_cnt_g); end
    endtask

    task automatic test_reset_mid_pop();
        int seen = 0;
        bit hit = 1'b0;
        begin_reset();
        push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h0004);
        rst = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (rinc) begin
                seen++;
                if (seen == 2) hit = 1'b1;
            end
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midpop_reach: got %0d pops want 2", seen); end
        #1 rst = 1'b1;
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL midpop_rinc: got %b want 0", rinc); end
        checks++; if (rword !== 16'h0) begin errors++; $display("FAIL midpop_rword: got %h want 0000", rword); end
        checks++; if (rcount !== 16'h0) begin errors++; $display("FAIL midpop_rcount: got %0d want 0", rcount); end
        checks++; if ({rvalid, perr, serr} !== 3'b000) begin errors++; $display("FAIL midpop_flags: got %b want 000", {rvalid, perr, serr}); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL midpop_err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk);
        wp = '0;
        push(0, 16'h0001); push(0, 16'h0002);
        rst = 1'b0;
        run(0, 12);
        checks++; if (nv !== 2) begin errors++; $display("FAIL midpop_after_count: got %0d want 2", nv); end
        checks++; if (vw[0] !== 16'h0001) begin errors++; $display("FAIL midpop_first: got %h want 0001", vw[0]); end
        checks++; if (serr !== 1'b0) begin errors++; $display("FAIL midpop_serr: got %b want 0", serr); end
        checks++; if (rcount !== 16'd2) begin errors++; $display("FAIL midpop_rcount_after: got %0d want 2", rcount); end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_parity();
        test_sequence();
        test_wrap();
        test_idle();
        test_gap();
        test_reset_mid_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
